// File: rtl/lab_pkg.sv
// Shared definitions for the lab evaluator blocks: the reference truth table,
// a table builder for future lab variants, and the loader FSM state type.
package lab_pkg;

  localparam int unsigned MAX_IN = 8;

  // (x|y) ^ (~z & (k|l)) with x=in[4] .. l=in[0]; bit i is f(in = i)
  localparam logic [31:0]  TT_VAR2   = 32'hF1F1_F10E;
  localparam logic [255:0] TT_VAR2_W = {224'd0, TT_VAR2};

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    LOAD = 1'b1
  } cfg_state_e;

  function automatic logic [255:0] build_tt(input int unsigned fn_idx, input int unsigned n_in);
    logic [255:0] tt;
    logic [7:0]   v;
    tt = 256'd0;
    for (int unsigned i = 0; i < 256; i++) begin
      v = 8'(i);
      if (i < (32'd1 << n_in)) begin
        case (fn_idx)
          32'd0:   tt[i] = ^v;
          32'd1:   tt[i] = &v;
          32'd2:   tt[i] = (v[4] | v[3]) ^ (~v[2] & (v[1] | v[0]));
          default: tt[i] = 1'b0;
        endcase
      end else begin
        tt[i] = 1'b0;
      end
    end
    return tt;
  endfunction

endpackage

// File: rtl/tt_loader.sv
// Serial truth-table loader: collects 2^N_IN bits into a shadow table and
// strobes a swap one cycle after the last bit is accepted.
module tt_loader
  import lab_pkg::*;
#(
  parameter int unsigned N_IN = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start_i,
  input  logic                   cfg_valid_i,
  input  logic                   cfg_bit_i,
  output logic                   cfg_busy_o,
  output logic                   cfg_done_o,
  output logic                   swap_o,
  output logic [(1<<N_IN)-1:0]   shadow_o
);

  localparam int unsigned DEPTH = 1 << N_IN;
  localparam logic [N_IN:0] TERM = {1'b0, {N_IN{1'b1}}};
  localparam logic [N_IN:0] ONE  = {{N_IN{1'b0}}, 1'b1};

  cfg_state_e        state_q, state_d;
  logic [N_IN:0]     cnt_q, cnt_d;
  logic [DEPTH-1:0]  shadow_q, shadow_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
    end
  end

  // Leaving LOAD straight to RUN on the last bit lets a cfg_start in the
  // swap cycle open a new load while the completed shadow is copied out.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (cfg_start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (cfg_start_i) begin
          cnt_d = '0;
        end else if (cfg_valid_i) begin
          shadow_d[cnt_q[N_IN-1:0]] = cfg_bit_i;
          cnt_d = cnt_q + ONE;
          if (cnt_q == TERM) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign cfg_busy_o = (state_q == LOAD);
  assign cfg_done_o = done_q;
  assign swap_o     = done_q;
  assign shadow_o   = shadow_q;

endmodule

// File: rtl/lut_eval_pipe.sv
// Two-stage registered truth-table evaluator with a run-time reloadable table;
// a new table is loaded serially into a shadow copy and swapped in atomically.
module lut_eval_pipe
  import lab_pkg::*;
#(
  parameter int unsigned              N_IN       = 5,
  parameter logic [(1<<N_IN)-1:0]     DEFAULT_TT = TT_VAR2_W[(1<<N_IN)-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [N_IN-1:0]   in_data,
  output logic              out_valid,
  output logic              out,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  output logic              cfg_busy,
  output logic              cfg_done
);

  localparam int unsigned DEPTH = 1 << N_IN;

  logic [N_IN-1:0]   s1_data_q;
  logic              s1_valid_q;
  logic              out_q, out_d;
  logic              out_valid_q;
  logic [DEPTH-1:0]  active_tt_q, active_tt_d;
  logic              swap_s;
  logic [DEPTH-1:0]  shadow_s;

  tt_loader #(
    .N_IN (N_IN)
  ) u_loader (
    .clk         (clk),
    .rst         (rst),
    .cfg_start_i (cfg_start),
    .cfg_valid_i (cfg_valid),
    .cfg_bit_i   (cfg_bit),
    .cfg_busy_o  (cfg_busy),
    .cfg_done_o  (cfg_done),
    .swap_o      (swap_s),
    .shadow_o    (shadow_s)
  );

  // The lookup reads the table as it stands before this edge's swap.
  always_comb begin
    out_d       = active_tt_q[s1_data_q];
    active_tt_d = active_tt_q;
    if (swap_s) begin
      active_tt_d = shadow_s;
    end else begin
      active_tt_d = active_tt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_q   <= '0;
      s1_valid_q  <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      active_tt_q <= DEFAULT_TT;
    end else begin
      s1_data_q   <= in_data;
      s1_valid_q  <= in_valid;
      out_q       <= out_d;
      out_valid_q <= s1_valid_q;
      active_tt_q <= active_tt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/lut_eval_pipe.md
Name: lut_eval_pipe

Overview:
- Registered, parametrised Boolean-function evaluator. It replaces the fixed 5-input lab function with a truth table of 2^N_IN entries that can be reloaded at run time.
- Inputs are sampled into a stage-1 register. The stage-2 output register holds the table lookup.
- A serial configuration port loads a new table into a shadow copy while evaluation continues. The shadow copy is swapped in atomically once loading completes.
- Used in the lab top levels as the generic combinational-function-under-clock block.

Parameters:
- N_IN, 5, number of function inputs (1..8); table depth is 2^N_IN.
- DEFAULT_TT, lab_pkg::TT_VAR2, truth table loaded at reset; bit i is f(in = i).

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data qualifier
- in_data  in  N_IN  function inputs; MSB is the first variable
- out_valid  out  1  out qualifier
- out  out  1  registered function value
- cfg_start  in  1  one-cycle pulse that begins a table load
- cfg_valid  in  1  cfg_bit qualifier
- cfg_bit  in  1  serial table bit, index 0 first
- cfg_busy  out  1  high while in LOAD
- cfg_done  out  1  one-cycle pulse on table swap

Behaviour:
- Reset (rst=1 at posedge):
  - Active table = DEFAULT_TT; shadow cleared.
  - FSM = RUN; bit counter = 0.
  - Stage-1 registers = 0; out = 0; out_valid = 0; cfg_busy = 0; cfg_done = 0.
  - Reset during LOAD discards the partial shadow.
- Datapath (latency 2, throughput 1/cycle, no backpressure):
  - Cycle k: in_data and in_valid are captured into stage 1.
  - Cycle k+1: out <= active_tt[stage1_data]; out_valid <= stage1_valid.
  - When out_valid=0, out still updates from the stage-1 data but is don't-care.
- FSM RUN:
  - cfg_start -> LOAD, counter = 0, cfg_busy = 1 from the next cycle.
  - cfg_valid is ignored in RUN.
- FSM LOAD:
  - Each cycle with cfg_valid=1: shadow[counter] <= cfg_bit, then counter++.
  - After bit 2^N_IN-1 is accepted, the next cycle performs the swap: active_tt <= shadow, cfg_done = 1 for that single cycle, FSM -> RUN, cfg_busy = 0.
  - Gaps in cfg_valid stretch the load without limit.
  - cfg_start in LOAD restarts the load at counter = 0; bits already shifted are discarded.
  - A cfg_start on the swap cycle is honoured after the swap (FSM -> LOAD).
- Table-boundary rule: the stage-2 lookup uses the active table as it stands at that posedge.
  - A sample in stage 1 on the swap posedge is evaluated with the OLD table.
  - A sample one cycle later is evaluated with the new table.
- Counter width is N_IN+1 bits. Terminal count is 2^N_IN-1; no wrap occurs.
- Evaluation never stalls during LOAD.

Decomposition:
- lab_pkg holds:
  - TT_VAR2 = the 32-bit table of (x|y) ^ (~z & (k|l)) with x=in[4] .. l=in[0].
  - A function that builds a table from a function index, for future lab variants.
  - The FSM state enum {RUN, LOAD}.
- One sub-module: tt_loader, containing the FSM, counter, shadow register, cfg_busy and cfg_done. It outputs a swap strobe and the shadow table.
- The datapath (stage registers and active table) stays in the top module.

Test Plan:
- Reset defaults, then the stream in_data = 5'b10000, 5'b00011, 5'b10011, 5'b00111 with in_valid=1. Required: out_valid rises 2 cycles after the first sample; out = 1, 1, 0, 0.
- Exhaustive check: all 32 inputs back-to-back -> out matches the TT_VAR2 bit for every input, with out_valid continuously 1.
- Load all-ones with cfg_valid gaps, streaming inputs throughout. Required: cfg_busy=1 for the whole load; cfg_done is a single pulse; samples in stage 1 at the swap edge use the old table; all later outputs are 1.
- cfg_start after 10 bits, then load alternating 0101... from index 0. Required: out = in_data[0] afterwards; the first 10 bits have no effect.
- rst asserted mid-load at bit 20. Required: cfg_busy=0, out_valid=0 next cycle; table = TT_VAR2 (5'b10000 -> 1); no cfg_done pulse.
- N_IN=3 build, load 8'b1000_0000. Required: out=1 only for in_data=3'b111; cfg_done follows the 8th bit by 1 cycle.
